morse_digit_keyer: RTL and testbench

Sequential Morse-code transmitter for the board-level Morse demo. It latches `DIGITS` BCD digits from the switches on a `ready` rising edge and keys each digit's 5-symbol Morse pattern on one LED with standard unit timing. Digits above 9 are rejected, and the red invalid flag is raised instead. It sits between the switch inputs and the LEDs, replacing the static per-digit pattern display with a timed, multi-digit, serial output.

---
 rtl/morse_digit_keyer.sv | 245 ++++++++++++++++++++++++
 tb/tb_morse_digit_keyer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_digit_keyer.sv
// morse_digit_keyer
// -----------------
// Serial Morse transmitter for BCD digits. A rising edge on `ready` while idle
// latches DIGITS BCD digits from `digits_in`. Each digit is keyed on `key_out`
// as its 5-symbol Morse pattern with standard unit timing:
//   dot = 1 unit, dash = 3 units, gap between symbols = 1 unit,
//   gap between digits = 3 units, no trailing gap after the last mark.
// A load containing any digit above 9 sets `invalid` and sends nothing.
//
// Parameters
//   UNIT_CYCLES : clock cycles per Morse time unit (>= 1)
//   DIGITS      : digits per message (>= 1)
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   digits_in   : BCD digits, most significant nibble is sent first
//   ready       : load request, acts on its rising edge only
//   key_out     : Morse key, 1 = mark
//   symbols_out : pattern of the digit being sent, bit 4 = first symbol, 1 = dash
//   busy        : message in progress
//   done        : one-cycle pulse as the last mark of a message ends
//   invalid     : last load attempt contained a digit above 9
module morse_digit_keyer #(
    parameter int UNIT_CYCLES = 12500000,
    parameter int DIGITS      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic                ready,
    output logic                key_out,
    output logic [4:0]          symbols_out,
    output logic                busy,
    output logic                done,
    output logic                invalid
);

    localparam int CW = $clog2(UNIT_CYCLES + 1);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MARK = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Morse digit table, dash = 1, first symbol in bit 4.
    function automatic logic [4:0] encode(input logic [3:0] d);
        logic [4:0] p;
        case (d)
            4'd0:    p = 5'b11111;
            4'd1:    p = 5'b01111;
            4'd2:    p = 5'b00111;
            4'd3:    p = 5'b00011;
            4'd4:    p = 5'b00001;
            4'd5:    p = 5'b00000;
            4'd6:    p = 5'b10000;
            4'd7:    p = 5'b11000;
            4'd8:    p = 5'b11100;
            4'd9:    p = 5'b11110;
            default: p = 5'b00000;
        endcase
        return p;
    endfunction

    // Registers
    state_t              r_state;
    logic [CW-1:0]       r_cyc;       // cycles left in the current unit, minus one
    logic [1:0]          r_left;      // units left in the current state, minus one
    logic [4*DIGITS-1:0] r_buf;       // digit shift buffer, current digit on top
    logic [DW-1:0]       r_dig_left;  // digits still to send after the current one
    logic [2:0]          r_sym;       // index of the current symbol within the digit
    logic [4:0]          r_pat;
    logic                r_ready_q;
    logic                r_key;
    logic                r_busy;
    logic                r_done;
    logic                r_invalid;

    // Next-state wires
    state_t              w_state_next;
    logic [CW-1:0]       w_cyc_next;
    logic [1:0]          w_left_next;
    logic [4*DIGITS-1:0] w_buf_next;
    logic [DW-1:0]       w_dig_left_next;
    logic [2:0]          w_sym_next;
    logic [4:0]          w_pat_next;
    logic                w_invalid_next;
    logic                w_done_next;
    logic                w_key_next;
    logic                w_busy_next;

    // Helpers
    logic [DIGITS-1:0]   w_digit_bad;
    logic                w_any_bad;
    logic                w_edge;
    logic                w_unit_end;
    logic                w_state_end;
    logic [4:0]          w_first_pat;
    logic [4*DIGITS-1:0] w_shift_buf;
    logic [4:0]          w_next_pat;
    logic [4:0]          w_pat_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit_check
            assign w_digit_bad[gi] = (digits_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_any_bad   = |w_digit_bad;
    assign w_edge      = ready & ~r_ready_q;
    assign w_unit_end  = (r_cyc == '0);
    assign w_state_end = w_unit_end && (r_left == 2'd0);
    assign w_first_pat = encode(digits_in[4*DIGITS-1 -: 4]);
    assign w_shift_buf = r_buf << 4;
    assign w_next_pat  = encode(w_shift_buf[4*DIGITS-1 -: 4]);
    // Bit 4 of this is the symbol that follows the current one.
    assign w_pat_shift = r_pat << (r_sym + 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_left     <= '0;
            r_buf      <= '0;
            r_dig_left <= '0;
            r_sym      <= '0;
            r_pat      <= '0;
            r_ready_q  <= 1'b1;   // a level held through reset is not an edge
            r_key      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cyc      <= w_cyc_next;
            r_left     <= w_left_next;
            r_buf      <= w_buf_next;
            r_dig_left <= w_dig_left_next;
            r_sym      <= w_sym_next;
            r_pat      <= w_pat_next;
            r_ready_q  <= ready;
            r_key      <= w_key_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_invalid  <= w_invalid_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cyc_next      = r_cyc;
        w_left_next     = r_left;
        w_buf_next      = r_buf;
        w_dig_left_next = r_dig_left;
        w_sym_next      = r_sym;
        w_pat_next      = r_pat;
        w_invalid_next  = r_invalid;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    if (w_any_bad) begin
                        w_invalid_next = 1'b1;
                    end else begin
                        w_invalid_next  = 1'b0;
                        w_buf_next      = digits_in;
                        w_dig_left_next = DIG_LAST;
                        w_sym_next      = 3'd0;
                        w_pat_next      = w_first_pat;
                        w_state_next    = S_MARK;
                        w_cyc_next      = UNIT_LAST;
                        w_left_next     = w_first_pat[4] ? 2'd2 : 2'd0;
                    end
                end
            end

            S_MARK: begin
                if (!w_state_end) begin
                    if (w_unit_end) begin
                        w_cyc_next  = UNIT_LAST;
                        w_left_next = r_left - 2'd1;
                    end else begin
                        w_cyc_next = r_cyc - CW'(1);
                    end
                end else if (r_sym != 3'd4) begin
                    w_state_next = S_GAP;
                    w_cyc_next   = UNIT_LAST;
                    w_left_next  = 2'd0;
                end else if (r_dig_left != '0) begin
                    w_state_next = S_GAP;
                    w_cyc_next   = UNIT_LAST;
                    w_left_next  = 2'd2;
                end else begin
                    // Last mark of the message: straight to idle, no trailing gap.
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end

            S_GAP: begin
                if (!w_state_end) begin
                    if (w_unit_end) begin
                        w_cyc_next  = UNIT_LAST;
                        w_left_next = r_left - 2'd1;
                    end else begin
                        w_cyc_next = r_cyc - CW'(1);
                    end
                end else if (r_sym == 3'd4) begin
                    // Inter-digit gap over: bring the next digit to the top.
                    w_buf_next      = w_shift_buf;
                    w_dig_left_next = r_dig_left - DW'(1);
                    w_sym_next      = 3'd0;
                    w_pat_next      = w_next_pat;
                    w_state_next    = S_MARK;
                    w_cyc_next      = UNIT_LAST;
                    w_left_next     = w_next_pat[4] ? 2'd2 : 2'd0;
                end else begin
                    w_sym_next   = r_sym + 3'd1;
                    w_state_next = S_MARK;
                    w_cyc_next   = UNIT_LAST;
                    w_left_next  = w_pat_shift[4] ? 2'd2 : 2'd0;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_key_next  = (w_state_next == S_MARK);
    assign w_busy_next = (w_state_next != S_IDLE);

    assign key_out     = r_key;
    assign symbols_out = r_pat;
    assign busy        = r_busy;
    assign done        = r_done;
    assign invalid     = r_invalid;

endmodule

// File: tb/tb_morse_digit_keyer.sv
// tb_morse_digit_keyer
// --------------------
// Self-checking bench for morse_digit_keyer. Instance A is a 2-digit keyer and
// instance B a 1-digit keyer, both with 2 clock cycles per unit. Expected
// waveforms come from a reference model that expands each digit's Morse rule
// into a per-cycle key/pattern sequence.
module tb_morse_digit_keyer;

    localparam int UNIT = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic [7:0] a_digits = 8'h00;
    logic       a_ready  = 1'b0;
    logic       a_key, a_busy, a_done, a_inv;
    logic [4:0] a_sym;

    logic [3:0] b_digits = 4'h0;
    logic       b_ready  = 1'b0;
    logic       b_key, b_busy, b_done, b_inv;
    logic [4:0] b_sym;

    int total = 0;
    int bad   = 0;
    int sel   = 0;   // 0 = instance A, 1 = instance B

    logic       exp_key[$];
    logic [4:0] exp_sym[$];
    int         busy_seen;
    int         key_seen;

    logic [8:0] a_vec, b_vec, obs_vec;
    assign a_vec   = {a_key, a_busy, a_done, a_inv, a_sym};
    assign b_vec   = {b_key, b_busy, b_done, b_inv, b_sym};
    assign obs_vec = (sel != 0) ? b_vec : a_vec;

    always #5 clk = ~clk;

    morse_digit_keyer #(.UNIT_CYCLES(UNIT), .DIGITS(2)) dut_a (
        .clk(clk), .reset(reset), .digits_in(a_digits), .ready(a_ready),
        .key_out(a_key), .symbols_out(a_sym), .busy(a_busy), .done(a_done),
        .invalid(a_inv)
    );

    morse_digit_keyer #(.UNIT_CYCLES(UNIT), .DIGITS(1)) dut_b (
        .clk(clk), .reset(reset), .digits_in(b_digits), .ready(b_ready),
        .key_out(b_key), .symbols_out(b_sym), .busy(b_busy), .done(b_done),
        .invalid(b_inv)
    );

    // Digits 0..4: first d symbols are dots, rest dashes.
    // Digits 5..9: first d-5 symbols are dashes, rest dots.
    function automatic logic [4:0] ref_pat(input int d);
        logic [4:0] p;
        p = '0;
        for (int k = 0; k < 5; k++)
            p[4-k] = (d <= 4) ? (k >= d) : (k < d - 5);
        return p;
    endfunction

    task automatic build_model(input int d0, input int d1, input int n);
        logic [4:0] p;
        int dg;
        int len;
        exp_key.delete();
        exp_sym.delete();
        for (int di = 0; di < n; di++) begin
            dg = (di == 0) ? d0 : d1;
            p  = ref_pat(dg);
            for (int k = 0; k < 5; k++) begin
                len = p[4-k] ? 3 : 1;
                for (int c = 0; c < UNIT * len; c++) begin
                    exp_key.push_back(1'b1);
                    exp_sym.push_back(p);
                end
                len = (k < 4) ? 1 : ((di < n - 1) ? 3 : 0);
                for (int c = 0; c < UNIT * len; c++) begin
                    exp_key.push_back(1'b0);
                    exp_sym.push_back(p);
                end
            end
        end
    endtask

    task automatic drive_ready(input logic v);
        if (sel != 0) b_ready = v; else a_ready = v;
    endtask

    task automatic drive_digits(input logic [7:0] v);
        if (sel != 0) b_digits = v[3:0]; else a_digits = v;
    endtask

    // Loads dg on the selected instance and checks every cycle of the message.
    // chain: ready is already low and we sit on the negedge after done.
    // then_chain: leave right after the done cycle so the next load is immediate.
    task automatic send(input logic [7:0] dg, input bit chain, input bit disturb,
                        input bit then_chain, input string name);
        int n;
        bit ok;
        logic [8:0] expv;
        logic [4:0] last_sym;
        if (sel != 0) build_model(int'(dg[3:0]), 0, 1);
        else          build_model(int'(dg[7:4]), int'(dg[3:0]), 2);
        n = exp_key.size();
        if (!chain) begin
            @(negedge clk);
            drive_ready(1'b0);
            @(negedge clk);
        end
        drive_digits(dg);
        drive_ready(1'b1);
        busy_seen = 0;
        key_seen  = 0;
        ok        = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            busy_seen += int'(obs_vec[7]);
            key_seen  += int'(obs_vec[8]);
            expv = {exp_key[i], 1'b1, 1'b0, 1'b0, exp_sym[i]};
            if (ok) begin
                total++;
                if (obs_vec !== expv) begin
                    bad++;
                    ok = 1'b0;
                    $display("FAIL %s cycle %0d key/busy/done/inv/sym got=%b required=%b",
                             name, i, obs_vec, expv);
                end
            end
            if (i == n - 1) begin
                drive_ready(1'b0);
            end else if (disturb) begin
                drive_ready(1'($urandom_range(0, 1)));
                drive_digits(8'($urandom));
            end
        end
        last_sym = exp_sym[n-1];
        @(negedge clk);
        busy_seen += int'(obs_vec[7]);
        key_seen  += int'(obs_vec[8]);
        expv = {1'b0, 1'b0, 1'b1, 1'b0, last_sym};
        total++;
        if (obs_vec !== expv) begin
            bad++;
            $display("FAIL %s done_cycle got=%b required=%b", name, obs_vec, expv);
        end
        if (!then_chain) begin
            @(negedge clk);
            busy_seen += int'(obs_vec[7]);
            expv = {1'b0, 1'b0, 1'b0, 1'b0, last_sym};
            total++;
            if (obs_vec !== expv) begin
                bad++;
                $display("FAIL %s after_done got=%b required=%b", name, obs_vec, expv);
            end
        end
        $display("msg %s digits=%h cycles=%0d", name, dg, n);
    endtask

    function automatic logic [7:0] rand_valid2();
        logic [3:0] h, l;
        h = 4'($urandom_range(0, 9));
        l = 4'($urandom_range(0, 9));
        return {h, l};
    endfunction

    task automatic test_reset();
        #3;
        total++;
        if (a_vec !== 9'b0) begin
            bad++;
            $display("FAIL reset_a got=%b required=%b", a_vec, 9'b0);
        end
        total++;
        if (b_vec !== 9'b0) begin
            bad++;
            $display("FAIL reset_b got=%b required=%b", b_vec, 9'b0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_basic();
        sel = 0;
        send(8'h15, 1'b0, 1'b0, 1'b0, "basic_15");
        total++;
        if (busy_seen !== 58) begin
            bad++;
            $display("FAIL basic_busy_cycles got=%0d required=58", busy_seen);
        end
        total++;
        if (key_seen !== 36) begin
            bad++;
            $display("FAIL basic_key_cycles got=%0d required=36", key_seen);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] v;
        int pos;
        sel = 0;
        for (int t = 0; t < 3; t++) begin
            v   = 8'($urandom);
            pos = $urandom_range(0, 1);
            v[pos*4 +: 4] = 4'($urandom_range(10, 15));
            @(negedge clk);
            a_ready = 1'b0;
            @(negedge clk);
            a_digits = v;
            a_ready  = 1'b1;
            @(negedge clk);
            total++;
            if ({a_inv, a_busy, a_key} !== 3'b100) begin
                bad++;
                $display("FAIL invalid_flag digits=%h inv/busy/key got=%b required=100",
                         v, {a_inv, a_busy, a_key});
            end
            repeat (4) @(negedge clk);
            total++;
            if ({a_inv, a_busy, a_key} !== 3'b100) begin
                bad++;
                $display("FAIL invalid_stays_idle digits=%h got=%b required=100",
                         v, {a_inv, a_busy, a_key});
            end
            $display("invalid load digits=%h", v);
        end
        send(8'h33, 1'b0, 1'b0, 1'b0, "after_invalid_33");
    endtask

    task automatic test_single_digit();
        sel = 1;
        send(8'h00, 1'b0, 1'b0, 1'b0, "single_0");
        total++;
        if (busy_seen !== 38) begin
            bad++;
            $display("FAIL single_busy_cycles got=%0d required=38", busy_seen);
        end
        total++;
        if (key_seen !== 30) begin
            bad++;
            $display("FAIL single_key_cycles got=%0d required=30", key_seen);
        end
        for (int t = 0; t < 3; t++)
            send({4'h0, 4'($urandom_range(0, 9))}, 1'b0, 1'b0, 1'b0, "single_rand");
        sel = 0;
    endtask

    task automatic test_random();
        sel = 0;
        for (int t = 0; t < 6; t++)
            send(rand_valid2(), 1'b0, 1'b0, 1'b0, "random");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        send(rand_valid2(), 1'b0, 1'b0, 1'b1, "b2b_first");
        send(rand_valid2(), 1'b1, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_disturb();
        sel = 0;
        send(rand_valid2(), 1'b0, 1'b1, 1'b0, "disturbed");
        send(8'h90, 1'b0, 1'b1, 1'b0, "disturbed_90");
    endtask

    task automatic test_reset_mid_dash();
        int busy_cnt;
        sel = 0;
        @(negedge clk);
        a_ready  = 1'b0;
        a_digits = 8'h05;
        @(negedge clk);
        a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (a_vec !== 9'b0) begin
            bad++;
            $display("FAIL reset_mid_dash_async got=%b required=%b", a_vec, 9'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            busy_cnt += int'(a_busy) + int'(a_key);
        end
        total++;
        if (busy_cnt !== 0) begin
            bad++;
            $display("FAIL reset_no_resume active_cycles got=%0d required=0", busy_cnt);
        end
        $display("reset mid dash checked");
    endtask

    task automatic test_ready_through_reset();
        int busy_cnt;
        sel = 0;
        @(negedge clk);
        a_ready  = 1'b1;
        a_digits = 8'h27;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        busy_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            busy_cnt += int'(a_busy) + int'(a_key);
        end
        total++;
        if (busy_cnt !== 0) begin
            bad++;
            $display("FAIL ready_held_no_load active_cycles got=%0d required=0", busy_cnt);
        end
        send(8'h27, 1'b0, 1'b0, 1'b0, "after_held_ready");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_single_digit();
        test_random();
        test_back_to_back();
        test_disturb();
        test_reset_mid_dash();
        test_ready_through_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
